// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed big-endian byte stream and writes instruction memory,
// holding the core in reset until done. Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
//   state   | meaning
//   LEN_HI  | waiting for word count [15:8]
//   LEN_LO  | waiting for word count [7:0]
//   DATA    | assembling a 32-bit word, MSB first
//   WRITE   | one-cycle instruction-memory write
//   CHK     | waiting for checksum byte (checksum build only)
//   DONE    | load complete, core released
//   ERROR   | bad length or checksum, core held in reset
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       index_q, index_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       new_count;
    logic              accept;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: s_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHK:                      s_ready = 1'b1;
`endif
            default:                    s_ready = 1'b0;
        endcase
    end

    assign accept = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        bidx_d    = bidx_q;
        word_d    = word_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        new_count = {count_q[15:8], s_data};
        case (state_q)
            S_LEN_HI: if (accept) begin
                count_d = {s_data, count_q[7:0]};
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                count_d = new_count;
                bidx_d  = 2'd0;
                if (new_count == 16'd0)              state_d = S_FINISH;
                else if ({1'b0, new_count} > DEPTH_L) state_d = S_ERROR;
                else                                  state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                word_d = {word_q[15:0], s_data};
                bidx_d = bidx_q + 2'd1;
                if (bidx_q == 2'd3) begin
                    addr_d  = index_q[ADDR_W-1:0];
                    wdata_d = {word_q, s_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                index_d = index_q + 16'd1;
                state_d = (index_q + 16'd1 == count_q) ? S_FINISH : S_DATA;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHK: if (accept) begin
                state_d = (s_data == xor_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: if (start) begin
                count_d = 16'd0;
                index_d = 16'd0;
                bidx_d  = 2'd0;
                state_d = S_LEN_HI;
            end
            default: state_d = S_ERROR;
        endcase
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum byte itself is excluded from the running XOR.
    always_comb begin
        xor_d = xor_q;
        if (accept && state_q != S_CHK)
            xor_d = xor_q ^ s_data;
        if (start && (state_q == S_DONE || state_q == S_ERROR))
            xor_d = 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) xor_q <= 8'd0;
        else        xor_q <= xor_d;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LEN_HI;
            count_q <= 16'd0;
            index_q <= 16'd0;
            bidx_q  <= 2'd0;
            word_q  <= 24'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERROR);
    assign core_reset = done;
    assign busy       = !(done || err);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader; expected writes come from a word-list model.
// Honours IMEM_BOOT_CHECKSUM_EN by appending the XOR checksum byte to every stream.
module tb_imem_boot_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'd0;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset, busy, done, err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            wr_t e;
            chk("ready_low_in_write", 32'(s_ready), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, expected none", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: s_ready stayed 0 for byte %h", b);
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_final(input bit ok);
        chk("done",       32'(done),       32'(ok));
        chk("core_reset", 32'(core_reset), 32'(ok));
        chk("err",        32'(err),        32'(!ok));
        chk("busy_end",   32'(busy),       32'd0);
        chk("ready_end",  32'(s_ready),    32'd0);
    endtask

    // Streams words[0..n-1]; bad_chk corrupts the checksum byte in checksum builds.
    task automatic load(input int n, input bit bad_chk, input int maxgap);
        logic [7:0] xr;
        logic [7:0] b;
        bit         ok;
        xr = 8'd0;
        ok = 1'b1;
        b = n[15:8]; xr ^= b; send_byte(b, $urandom_range(maxgap));
        b = n[7:0];  xr ^= b; send_byte(b, $urandom_range(maxgap));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[i][31-8*k -: 8];
                xr ^= b;
                if (k == 3) exp_q.push_back({ADDR_W'(i), words[i]});
                send_byte(b, $urandom_range(maxgap));
            end
            chk("we_latency", 32'(imem_we), 32'd1);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (bad_chk) begin
            ok = 1'b0;
            send_byte((xr == 8'd0) ? 8'hFF : 8'h00, $urandom_range(maxgap));
        end else begin
            send_byte(xr, $urandom_range(maxgap));
        end
`else
        if (n > 0) @(negedge clk);
`endif
        check_final(ok);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Start with a coincident byte on s_valid: that byte must not be taken.
    task automatic pulse_start();
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        chk("start_busy",       32'(busy),       32'd1);
        chk("start_ready",      32'(s_ready),    32'd1);
        chk("start_core_reset", 32'(core_reset), 32'd0);
        chk("start_done",       32'(done),       32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we",         32'(imem_we),    32'd0);
        chk("rst_addr",       32'(imem_addr),  32'd0);
        chk("rst_wdata",      imem_wdata,      32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd0);
        chk("rst_busy",       32'(busy),       32'd1);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_err",        32'(err),        32'd0);
        chk("rst_ready",      32'(s_ready),    32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        words[0] = 32'h20080005;
        words[1] = 32'hAC080040;
        load(2, 1'b0, 0);

        pulse_start();
        load(0, 1'b0, 0);

        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_final(1'b0);
        repeat (3) @(negedge clk);
        chk("overflow_stays_err", 32'(err), 32'd1);

        pulse_start();
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        load(DEPTH, 1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            pulse_start();
            for (int i = 0; i < 3; i++) words[i] = $urandom;
            load(3, 1'b0, (r == 0) ? 0 : 3);
        end

        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        words[0] = $urandom;
        words[1] = $urandom;
        load(2, 1'b0, 2);
        pulse_start();
        words[0] = 32'hDEADBEEF;
        load(1, 1'b0, 1);

`ifdef IMEM_BOOT_CHECKSUM_EN
        pulse_start();
        words[0] = 32'h11223344;
        load(1, 1'b0, 0);
        pulse_start();
        load(1, 1'b1, 0);
        pulse_start();
        load(0, 1'b1, 0);
        pulse_start();
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        load(3, 1'b0, 2);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
